// File: rtl/cmd_sched.sv
// -----------------------------------------------------------------------------
// cmd_sched
//   Command scheduler sitting between a first-word-fall-through command FIFO
//   and an HLS accelerator using the ap_ctrl_hs handshake. Each command word
//   carries an input dependency mask, an output dependency mask and a repeat
//   count. One ap_start handshake is issued per repetition, gated only on the
//   channels selected by the masks. Up to MAX_INFLIGHT invocations may be
//   outstanding; their output masks are queued and retired in order on ap_done
//   as out_commit pulses.
//
//   Command word: [CMD_W-1 -: 16] repeat count,
//                 [NUM_IN_ARGS +: NUM_OUT_ARGS] output mask,
//                 [NUM_IN_ARGS-1:0] input mask, remaining bits reserved.
//
//   Optional feature macro: CMD_SCHED_WATCHDOG_EN
//     Defined   : a WAIT_READY that lasts WDOG_CYCLES cycles aborts the
//                 command and sets the sticky wdog_err flag.
//     Undefined : WAIT_READY waits indefinitely, wdog_err is tied to 0.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   cmd_din          command word (valid whenever cmd_empty = 0)
//   cmd_empty        command FIFO empty
//   cmd_read         dequeue pulse (combinational, same cycle as capture)
//   ap_start         accelerator start level
//   ap_start_single  one-cycle pulse on each ap_start rise
//   ap_ready         accelerator accepted the start
//   ap_done          accelerator finished one invocation (pulse)
//   in_ready         per-input-channel data available
//   out_ready        per-output-channel space available
//   in_next          per-input-channel consume pulse
//   out_commit       per-output-channel commit pulse
//   inflight         number of outstanding invocations
//   busy             state != IDLE or inflight != 0
//   cmd_done         pulse: last repetition of a command has been started
//   wdog_err         sticky watchdog error
// -----------------------------------------------------------------------------
module cmd_sched #(
  parameter int NUM_IN_ARGS  = 4,
  parameter int NUM_OUT_ARGS = 4,
  parameter int CMD_W        = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CMD_W-1:0]                  cmd_din,
  input  logic                              cmd_empty,
  output logic                              cmd_read,
  output logic                              ap_start,
  output logic                              ap_start_single,
  input  logic                              ap_ready,
  input  logic                              ap_done,
  input  logic [NUM_IN_ARGS-1:0]            in_ready,
  input  logic [NUM_OUT_ARGS-1:0]           out_ready,
  output logic [NUM_IN_ARGS-1:0]            in_next,
  output logic [NUM_OUT_ARGS-1:0]           out_commit,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              busy,
  output logic                              cmd_done,
  output logic                              wdog_err
);

  localparam int INFL_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int PTR_W  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  if (NUM_IN_ARGS < 1 || NUM_IN_ARGS > 8 || NUM_OUT_ARGS < 1 || NUM_OUT_ARGS > 8 ||
      NUM_IN_ARGS + NUM_OUT_ARGS > CMD_W - 16 || WDOG_CYCLES < 1 ||
      MAX_INFLIGHT < 1 || MAX_INFLIGHT > 16 ||
      (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) begin : g_bad_params
    $error("cmd_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DEPS  = 2'd1,
    WAIT_READY = 2'd2
  } state_t;

  state_t state, state_d;

  // Captured command fields.
  logic [NUM_IN_ARGS-1:0]  in_mask;
  logic [NUM_OUT_ARGS-1:0] out_mask;
  logic [15:0]             rep;

  // Decoded fields of the word at the FIFO head.
  logic [NUM_IN_ARGS-1:0]  din_in_mask;
  logic [NUM_OUT_ARGS-1:0] din_out_mask;
  logic [15:0]             din_rep;
  logic                    unused_din;

  assign din_in_mask  = cmd_din[NUM_IN_ARGS-1:0];
  assign din_out_mask = cmd_din[NUM_IN_ARGS+NUM_OUT_ARGS-1:NUM_IN_ARGS];
  assign din_rep      = cmd_din[CMD_W-1 -: 16];
  // The bits between the masks and the repeat count are reserved.
  assign unused_din   = ^cmd_din;

  // Output-mask queue; occupancy equals inflight, so no separate count.
  logic [NUM_OUT_ARGS-1:0] mask_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;

  logic deps_ok, accept, retire, capture, wdog_trip;
  logic ap_start_d, ap_start_single_d, cmd_done_d;
  logic [NUM_IN_ARGS-1:0] in_next_d;

  assign deps_ok = (&(in_ready | ~in_mask)) && (&(out_ready | ~out_mask)) &&
                   (inflight < INFL_W'(MAX_INFLIGHT));
  // ap_start is always high in WAIT_READY, so ap_ready elsewhere is ignored.
  assign accept  = (state == WAIT_READY) && ap_ready;
  // A done with nothing outstanding must neither pop nor underflow.
  assign retire  = ap_done && (inflight != '0);
  assign busy    = (state != IDLE) || (inflight != '0);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d           = state;
    cmd_read          = 1'b0;
    capture           = 1'b0;
    ap_start_d        = 1'b0;
    ap_start_single_d = 1'b0;
    cmd_done_d        = 1'b0;
    in_next_d         = '0;
    unique case (state)
      IDLE: begin
        // Gated with rst so a reset cycle never pops the FIFO.
        if (!cmd_empty && !rst) begin
          cmd_read = 1'b1;
          capture  = 1'b1;
          if (din_rep != 16'd0) state_d    = WAIT_DEPS;
          else                  cmd_done_d = 1'b1;
        end
      end
      WAIT_DEPS: begin
        if (deps_ok) begin
          ap_start_d        = 1'b1;
          ap_start_single_d = 1'b1;
          state_d           = WAIT_READY;
        end
      end
      WAIT_READY: begin
        ap_start_d = 1'b1;
        if (ap_ready) begin
          ap_start_d = 1'b0;
          in_next_d  = in_mask;
          if (rep == 16'd1) begin
            cmd_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_DEPS;
          end
        end else if (wdog_trip) begin
          ap_start_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state           <= IDLE;
      ap_start        <= 1'b0;
      ap_start_single <= 1'b0;
      cmd_done        <= 1'b0;
      in_next         <= '0;
      out_commit      <= '0;
    end else begin
      state           <= state_d;
      ap_start        <= ap_start_d;
      ap_start_single <= ap_start_single_d;
      cmd_done        <= cmd_done_d;
      in_next         <= in_next_d;
      out_commit      <= retire ? mask_mem[rd_ptr] : '0;
    end
  end

  // Command fields, repeat counter, queue pointers and inflight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_mask  <= '0;
      out_mask <= '0;
      rep      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (capture) begin
        in_mask  <= din_in_mask;
        out_mask <= din_out_mask;
        rep      <= din_rep;
      end else if (accept) begin
        rep <= rep - 16'd1;
      end else if (wdog_trip) begin
        rep <= '0;
      end
      if (accept) wr_ptr <= (wr_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (retire) rd_ptr <= (rd_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves the count unchanged.
      unique case ({accept, retire})
        2'b10:   inflight <= inflight + INFL_W'(1);
        2'b01:   inflight <= inflight - INFL_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // NOTE: the queue storage has no reset; the pointers alone define its content.
  always_ff @(posedge clk) begin
    if (accept) mask_mem[wr_ptr] <= out_mask;
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT_READY watchdog
  // ---------------------------------------------------------------------------
`ifdef CMD_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            wdog_flag;

  // wdog_cnt holds the number of WAIT_READY cycles already elapsed, so the
  // trip fires on the WDOG_CYCLES-th cycle of waiting.
  assign wdog_trip = (state == WAIT_READY) && !ap_ready &&
                     (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
  assign wdog_err  = wdog_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_flag <= 1'b0;
    end else begin
      if (state == WAIT_READY && state_d == WAIT_READY) wdog_cnt <= wdog_cnt + WD_W'(1);
      else                                              wdog_cnt <= '0;
      if (wdog_trip) wdog_flag <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_cmd_sched
//   Directed bench for cmd_sched. Stimulus tasks push expected in_next and
//   out_commit values into queues at the moment the matching handshake is
//   driven; an independent monitor on the falling edge pops and compares
//   whenever the DUT presents a pulse. Event counters (reads, starts, done
//   pulses) are compared against hand-computed totals.
// -----------------------------------------------------------------------------
module tb_cmd_sched;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int CW = 32;
  localparam int MI = 4;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cmd_din = '0;
  logic          cmd_empty = 1'b1;
  logic          cmd_read;
  logic          ap_start, ap_start_single;
  logic          ap_ready = 1'b0;
  logic          ap_done = 1'b0;
  logic [NI-1:0] in_ready = '1;
  logic [NO-1:0] out_ready = '1;
  logic [NI-1:0] in_next;
  logic [NO-1:0] out_commit;
  logic [$clog2(MI):0] inflight;
  logic          busy, cmd_done, wdog_err;

  always #5 clk = ~clk;

  cmd_sched #(
    .NUM_IN_ARGS (NI),
    .NUM_OUT_ARGS(NO),
    .CMD_W       (CW),
    .MAX_INFLIGHT(MI),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_din        (cmd_din),
    .cmd_empty      (cmd_empty),
    .cmd_read       (cmd_read),
    .ap_start       (ap_start),
    .ap_start_single(ap_start_single),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .in_ready       (in_ready),
    .out_ready      (out_ready),
    .in_next        (in_next),
    .out_commit     (out_commit),
    .inflight       (inflight),
    .busy           (busy),
    .cmd_done       (cmd_done),
    .wdog_err       (wdog_err)
  );

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] fifo[$];
  logic [NI-1:0] exp_in_next[$];
  logic [NO-1:0] exp_commit[$];

  int rd_cnt = 0, done_cnt = 0, start_cnt = 0;
  int exp_reads = 0, exp_done = 0, exp_starts = 0;
  logic rd_pend = 1'b0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    rd_pend = cmd_read;
    if (cmd_read === 1'b1) rd_cnt++;
    if (cmd_done === 1'b1) done_cnt++;
    if (ap_start_single === 1'b1) start_cnt++;
    check("start_single_edge", {31'd0, ap_start_single}, {31'd0, ap_start & ~prev_start});
    prev_start = ap_start;
    if (in_next !== '0) begin
      if (exp_in_next.size() == 0) check("in_next_unexpected", {28'd0, in_next}, 32'd0);
      else                         check("in_next", {28'd0, in_next}, {28'd0, exp_in_next.pop_front()});
    end
    if (out_commit !== '0) begin
      if (exp_commit.size() == 0) check("out_commit_unexpected", {28'd0, out_commit}, 32'd0);
      else                        check("out_commit", {28'd0, out_commit}, {28'd0, exp_commit.pop_front()});
    end
  end

  // FWFT command FIFO model: pops two time units after an edge with cmd_read.
  always @(posedge clk) begin
    #2;
    if (rd_pend && fifo.size() > 0) void'(fifo.pop_front());
    cmd_empty = (fifo.size() == 0);
    cmd_din   = (fifo.size() > 0) ? fifo[0] : '0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [NI-1:0] im, input logic [NO-1:0] om, input logic [15:0] r);
    fifo.push_back({r, 8'h00, om, im});
    exp_reads++;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (ap_start !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, ap_start}, 32'd1);
  endtask

  task automatic ready_pulse(input logic [NI-1:0] im, input logic [NO-1:0] om);
    ap_ready = 1'b1;
    if (im != '0) exp_in_next.push_back(im);
    if (om != '0) exp_commit.push_back(om);
    tick(1);
    ap_ready = 1'b0;
  endtask

  task automatic done_pulse();
    ap_done = 1'b1;
    tick(1);
    ap_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_ap_start", {31'd0, ap_start}, 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_read", {31'd0, cmd_read}, 32'd0);
    check("rst_cmd_done", {31'd0, cmd_done}, 32'd0);
    check("rst_wdog_err", {31'd0, wdog_err}, 32'd0);
    check("rst_in_next", {28'd0, in_next}, 32'd0);
    check("rst_out_commit", {28'd0, out_commit}, 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: single repetition, ap_ready two cycles after start
    push_cmd(4'b0011, 4'b0001, 16'd1);
    exp_starts += 1;
    exp_done   += 1;
    wait_start("t1_start");
    tick(1);
    check("t1_start_c2", {31'd0, ap_start}, 32'd1);
    tick(1);
    check("t1_start_c3", {31'd0, ap_start}, 32'd1);
    ready_pulse(4'b0011, 4'b0001);
    check("t1_start_fall", {31'd0, ap_start}, 32'd0);
    check("t1_inflight1", 32'(inflight), 32'd1);
    check("t1_busy_inflight", {31'd0, busy}, 32'd1);
    tick(2);
    done_pulse();
    check("t1_inflight0", 32'(inflight), 32'd0);
    check("t1_busy0", {31'd0, busy}, 32'd0);

    // 2: input dependency holds off starts, then three repetitions
    in_ready = 4'b1110;
    push_cmd(4'b0001, 4'b0000, 16'd3);
    tick(10);
    check("t2_blocked", {31'd0, ap_start}, 32'd0);
    check("t2_no_start", 32'(start_cnt), 32'(exp_starts));
    in_ready = 4'b1111;
    exp_starts += 3;
    for (int r = 0; r < 3; r++) begin
      wait_start("t2_start");
      ready_pulse(4'b0001, 4'b0000);
      tick(1);
      check("t2_cmd_done", 32'(done_cnt), 32'(exp_done + ((r == 2) ? 1 : 0)));
    end
    exp_done += 1;
    check("t2_inflight3", 32'(inflight), 32'd3);
    for (int i = 0; i < 3; i++) done_pulse();
    check("t2_inflight0", 32'(inflight), 32'd0);

    // 3: MAX_INFLIGHT gate with ap_done withheld
    push_cmd(4'b0000, 4'b0010, 16'd6);
    exp_starts += 6;
    for (int r = 0; r < 4; r++) begin
      wait_start("t3_start");
      ready_pulse(4'b0000, 4'b0010);
    end
    tick(5);
    check("t3_inflight_full", 32'(inflight), 32'd4);
    check("t3_gate_blocked", {31'd0, ap_start}, 32'd0);
    done_pulse();
    wait_start("t3_fifth_start");
    ready_pulse(4'b0000, 4'b0010);
    check("t3_inflight_refill", 32'(inflight), 32'd4);
    done_pulse();
    wait_start("t3_sixth_start");
    ready_pulse(4'b0000, 4'b0010);
    exp_done += 1;
    for (int i = 0; i < 4; i++) done_pulse();
    check("t3_inflight0", 32'(inflight), 32'd0);

    // 4: in-order commits and simultaneous ready + done
    push_cmd(4'b0000, 4'b0100, 16'd1);
    push_cmd(4'b0000, 4'b1000, 16'd1);
    exp_starts += 2;
    exp_done   += 2;
    wait_start("t4_start_a");
    ready_pulse(4'b0000, 4'b0100);
    wait_start("t4_start_b");
    ap_ready = 1'b1;
    ap_done  = 1'b1;
    exp_commit.push_back(4'b1000);
    tick(1);
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    check("t4_inflight_same", 32'(inflight), 32'd1);
    done_pulse();
    check("t4_inflight0", 32'(inflight), 32'd0);

    // 5: zero repeat count and spurious ap_done
    push_cmd(4'b1111, 4'b1111, 16'd0);
    exp_done += 1;
    tick(4);
    check("t5_cmd_done", 32'(done_cnt), 32'(exp_done));
    check("t5_no_start", {31'd0, ap_start}, 32'd0);
    check("t5_idle", {31'd0, busy}, 32'd0);
    done_pulse();
    tick(1);
    check("t5_spurious_done", 32'(inflight), 32'd0);

    // 6: reset asserted mid WAIT_READY with one invocation outstanding
    push_cmd(4'b0001, 4'b0000, 16'd2);
    exp_starts += 2;
    wait_start("t6_start_a");
    ready_pulse(4'b0001, 4'b0000);
    wait_start("t6_start_b");
    check("t6_inflight1", 32'(inflight), 32'd1);
    rst = 1'b1;
    tick(1);
    check("t6_rst_ap_start", {31'd0, ap_start}, 32'd0);
    check("t6_rst_inflight", 32'(inflight), 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_cmd_read", {31'd0, cmd_read}, 32'd0);
    rst = 1'b0;
    tick(3);
    check("t6_stays_idle", {31'd0, busy}, 32'd0);

`ifdef CMD_SCHED_WATCHDOG_EN
    // 7: watchdog aborts a start that is never accepted
    begin
      int hi = 0;
      push_cmd(4'b0001, 4'b0000, 16'd2);
      exp_starts += 1;
      wait_start("t7_start");
      while (ap_start === 1'b1 && hi < 40) begin
        tick(1);
        hi++;
      end
      check("t7_start_cycles", 32'(hi), 32'(WD));
      check("t7_wdog_err", {31'd0, wdog_err}, 32'd1);
      check("t7_idle", {31'd0, busy}, 32'd0);
      tick(5);
      check("t7_wdog_sticky", {31'd0, wdog_err}, 32'd1);
      check("t7_no_restart", {31'd0, ap_start}, 32'd0);
      rst = 1'b1;
      tick(1);
      check("t7_wdog_cleared", {31'd0, wdog_err}, 32'd0);
      rst = 1'b0;
      tick(2);
    end
`else
    check("wdog_tied_low", {31'd0, wdog_err}, 32'd0);
`endif

    // Totals and leftover expectations
    tick(3);
    check("leftover_in_next", 32'(exp_in_next.size()), 32'd0);
    check("leftover_commit", 32'(exp_commit.size()), 32'd0);
    check("total_reads", 32'(rd_cnt), 32'(exp_reads));
    check("total_done", 32'(done_cnt), 32'(exp_done));
    check("total_starts", 32'(start_cnt), 32'(exp_starts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_sched.md
Name: cmd_sched

Overview:
- Parametrised command scheduler between the command-queue FIFO and an HLS accelerator.
- Each command word carries a per-argument dependency mask and a repeat count.
- The block issues one ap_start handshake per repetition, gated only on the masked arguments.
- Up to MAX_INFLIGHT invocations may be outstanding; output-argument commit masks are retired in order on ap_done.

Parameters:
- NUM_IN_ARGS, 4, input argument channels (scalar/BRAM/FIFO), 1..8
- NUM_OUT_ARGS, 4, output argument channels, 1..8
- CMD_W, 32, command word width; NUM_IN_ARGS+NUM_OUT_ARGS <= CMD_W-16
- MAX_INFLIGHT, 4, maximum outstanding starts (ap_ready seen, ap_done not yet seen), power of 2, 1..16
- WDOG_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_din  in  CMD_W  command word; first-word-fall-through, valid whenever cmd_empty=0
- cmd_empty  in  1  command FIFO empty
- cmd_read  out  1  dequeue pulse
- ap_start  out  1  accelerator start, level
- ap_start_single  out  1  one-cycle pulse on each ap_start rise
- ap_ready  in  1  accelerator accepted start
- ap_done  in  1  accelerator finished one invocation, one-cycle pulse
- in_ready  in  NUM_IN_ARGS  per-channel input available
- out_ready  in  NUM_OUT_ARGS  per-channel output space available
- in_next  out  NUM_IN_ARGS  consume pulse per channel
- out_commit  out  NUM_OUT_ARGS  commit pulse per channel
- inflight  out  clog2(MAX_INFLIGHT)+1  outstanding invocation count
- busy  out  1  state != IDLE or inflight != 0
- cmd_done  out  1  pulse: last repetition of a command has been started
- wdog_err  out  1  sticky watchdog error (0 when feature compiled out)

Behaviour:
- Reset: all outputs 0, state IDLE, inflight 0, mask queue empty, repeat counter 0.
- Command fields:
  - in_mask = din[NUM_IN_ARGS-1:0]
  - out_mask = din[NUM_IN_ARGS+NUM_OUT_ARGS-1:NUM_IN_ARGS]
  - rep = din[CMD_W-1:CMD_W-16]
- IDLE: if cmd_empty=0, assert cmd_read for 1 cycle and capture all fields the same cycle.
  - rep=0: discard the command, pulse cmd_done next cycle, stay IDLE.
  - rep>0: go to WAIT_DEPS.
- WAIT_DEPS: the following condition is required to proceed:
  - &(in_ready | ~in_mask)
  - and &(out_ready | ~out_mask)
  - and inflight < MAX_INFLIGHT
  - When it holds: ap_start<=1, ap_start_single<=1 for one cycle, go to WAIT_READY.
  - A zero mask means no dependency on that side.
- WAIT_READY: hold ap_start=1 until ap_ready=1. On that cycle:
  - ap_start<=0
  - in_next<=in_mask (1-cycle pulse)
  - push out_mask into the mask queue
  - inflight increments
  - decrement rep; if the new rep=0, pulse cmd_done and go to IDLE, else go to WAIT_DEPS.
- ap_start falls in the cycle after ap_ready; an ap_ready while ap_start=0 is ignored.
- ap_done: pop the head of the mask queue and drive out_commit<=head for 1 cycle; inflight decrements.
  - ap_done with inflight=0 is ignored (no pop, no pulse, no underflow).
- ap_done and ap_ready accepted in the same cycle: push and pop both occur, inflight unchanged.
- Mask queue: depth MAX_INFLIGHT, wrap-around pointers. It can never overflow because the start gate blocks at full.
- Back-to-back commands: the earliest dequeue of the next command is the cycle after returning to IDLE.
- rst mid-operation: everything is cleared immediately; outstanding invocations are forgotten and ap_start drops on the next edge.

Optional Feature:
- Macro: CMD_SCHED_WATCHDOG_EN.
- With the macro defined:
  - A counter runs while in WAIT_READY and clears on leaving it.
  - When the counter reaches WDOG_CYCLES: set wdog_err (sticky until rst), drop ap_start, return to IDLE, discard remaining repetitions, no in_next pulse.
- Without the macro: no counter, wdog_err tied to 0, WAIT_READY waits indefinitely.

Test Plan:
- in_mask=0b0011, out_mask=0b0001, rep=1, all ready, ap_ready 2 cycles after start -> one cmd_read, ap_start high 3 cycles, in_next=0011 one pulse, inflight=1; ap_done -> out_commit=0001, inflight=0, busy=0.
- rep=3, in_ready[0]=0 for 10 cycles with in_mask=0001 -> no ap_start until in_ready[0]=1; then 3 starts, cmd_done once, after the third ap_ready.
- MAX_INFLIGHT=4, rep=6, ap_done withheld -> exactly 4 ap_ready handshakes, inflight=4, ap_start stays 0; one ap_done -> fifth start issued.
- Two commands with out_mask 0100 then 1000, done in order -> out_commit sequence 0100, 1000; same-cycle ap_ready+ap_done -> inflight unchanged.
- rep=0 command -> cmd_read plus cmd_done pulses, no ap_start; spurious ap_done at inflight=0 -> no out_commit, inflight=0.
- CMD_SCHED_WATCHDOG_EN with WDOG_CYCLES=16, ap_ready never asserted -> ap_start drops after 16 cycles, wdog_err=1 until rst; rst asserted mid-WAIT_READY -> all outputs 0 next cycle.
